mux_stream_deser: RTL and testbench

- Downstream consumer of the registered 1-bit mux output stream; collects serial bits into WORD_W-bit words.
- Framing is defined by frame_start; gaps are allowed because each bit is qualified by bit_valid.
- Completed words leave through a single-entry output register with a valid/ready handshake.
- Sits between the select mux and the word-oriented datapath.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/mux_stream_outbuf.sv | 56 +++++
 rtl/mux_stream_deser.sv | 136 +++++++++++++
 tb/tb_mux_stream_deser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the select-mux stage and the stream deserialiser.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_pkg;

    // Deserialiser FSM encodings
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } deser_state_t;

    // Default number of data bits per assembled word
    localparam int DEFAULT_WORD_W = 8;

    // Select codes driven into the upstream mux stage
    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } mux_sel_t;

endpackage

// File: rtl/mux_stream_outbuf.sv
// Single-entry output register with valid/ready handshake and sticky drop flag.
// Latency: a load request appears on o_vld/o_dat the following cycle.
// Backpressure: accepts a load when empty or draining this cycle; otherwise drops it and sets o_overflow.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   i_load_vld/_dat     completed word offered for loading
//   i_rdy               consumer takes o_dat this cycle
//   o_dat/o_vld         held word and its valid flag
//   o_overflow          sticky: a load was refused (cleared only by reset)
module mux_stream_outbuf #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_load_vld,
    input  logic [DW-1:0] i_load_dat,
    input  logic          i_rdy,
    output logic [DW-1:0] o_dat,
    output logic          o_vld,
    output logic          o_overflow
);

    logic [DW-1:0] r_dat;
    logic          r_vld;
    logic          r_ovf;
    logic          w_free;

    // Slot is usable when empty, or when its current word leaves this same cycle
    assign w_free = ~r_vld | i_rdy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dat <= '0;
            r_vld <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (i_load_vld && w_free) begin
                r_dat <= i_load_dat;
                r_vld <= 1'b1;
            end else begin
                if (i_load_vld) begin
                    r_ovf <= 1'b1;
                end
                if (r_vld && i_rdy) begin
                    r_vld <= 1'b0;
                end
            end
        end
    end

    assign o_dat      = r_dat;
    assign o_vld      = r_vld;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/mux_stream_deser.sv
// Deserialises the 1-bit mux stream into WORD_W-bit words framed by frame_start.
// Latency: word appears on word_out one cycle after its final bit is accepted.
// Backpressure: single output slot; a word completing while the slot is held is dropped and flags overflow.
//
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   bit_in, bit_valid, frame_start serial input; frame_start marks bit 0 of a word
//   word_out, word_valid, word_ready  assembled word with valid/ready handshake
//   bit_count                      data bits collected in the word in progress
//   overflow                       sticky dropped-word flag
//   parity_err                     (MUX_STREAM_DESER_PARITY_EN only) even-parity check result
// Build option: define MUX_STREAM_DESER_PARITY_EN to append an even-parity bit to each word.
module mux_stream_deser
    import mux_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    input  logic                         frame_start,
    output logic [WORD_W-1:0]            word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(WORD_W+1)-1:0]  bit_count,
    output logic                         overflow
`ifdef MUX_STREAM_DESER_PARITY_EN
    ,
    output logic                         parity_err
`endif
);

    localparam int CW = $clog2(WORD_W + 1);

    deser_state_t      r_state;
    deser_state_t      w_state_nxt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              w_done;
`ifdef MUX_STREAM_DESER_PARITY_EN
    logic              w_perr;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_done      = 1'b0;
`ifdef MUX_STREAM_DESER_PARITY_EN
        w_perr      = 1'b0;
`endif
        if (bit_valid) begin
            if (frame_start) begin
                // Restart from any state: a partial word is abandoned without complaint
                w_shift_nxt    = '0;
                w_shift_nxt[0] = bit_in;
                w_count_nxt    = CW'(1);
                w_state_nxt    = COLLECT;
            end else begin
                case (r_state)
                    COLLECT: begin
                        for (int i = 0; i < WORD_W; i++) begin
                            if (r_count == CW'(i)) begin
                                w_shift_nxt[i] = bit_in;
                            end
                        end
                        if (r_count == CW'(WORD_W - 1)) begin
`ifdef MUX_STREAM_DESER_PARITY_EN
                            w_count_nxt = CW'(WORD_W);
                            w_state_nxt = PARITY;
`else
                            w_count_nxt = '0;
                            w_state_nxt = IDLE;
                            w_done      = 1'b1;
`endif
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
`ifdef MUX_STREAM_DESER_PARITY_EN
                    PARITY: begin
                        // Even parity: a clean word XORs to zero including the parity bit
                        w_perr      = ^{r_shift, bit_in};
                        w_done      = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef MUX_STREAM_DESER_PARITY_EN
    mux_stream_outbuf #(.DW(WORD_W + 1)) u_outbuf (
        .clock      (clock),
        .reset      (reset),
        .i_load_vld (w_done),
        .i_load_dat ({w_perr, w_shift_nxt}),
        .i_rdy      (word_ready),
        .o_dat      ({parity_err, word_out}),
        .o_vld      (word_valid),
        .o_overflow (overflow)
    );
`else
    mux_stream_outbuf #(.DW(WORD_W)) u_outbuf (
        .clock      (clock),
        .reset      (reset),
        .i_load_vld (w_done),
        .i_load_dat (w_shift_nxt),
        .i_rdy      (word_ready),
        .o_dat      (word_out),
        .o_vld      (word_valid),
        .o_overflow (overflow)
    );
`endif

    assign bit_count = r_count;

endmodule

// File: tb/tb_mux_stream_deser.sv
module tb_mux_stream_deser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_out;
    logic       word_valid;
    logic [3:0] bit_count;
    logic       overflow;
    logic [1:0] word_out2;
    logic       word_valid2;
    logic [1:0] bit_count2;
    logic       overflow2;
`ifdef MUX_STREAM_DESER_PARITY_EN
    logic       parity_err;
    logic       parity_err2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    mux_stream_deser #(.WORD_W(8)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .bit_count   (bit_count),
        .overflow    (overflow)
`ifdef MUX_STREAM_DESER_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    // Narrowest legal width, sharing the same stimulus
    mux_stream_deser #(.WORD_W(2)) u_dut2 (
        .clock       (clock),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .word_out    (word_out2),
        .word_valid  (word_valid2),
        .word_ready  (word_ready),
        .bit_count   (bit_count2),
        .overflow    (overflow2)
`ifdef MUX_STREAM_DESER_PARITY_EN
        ,
        .parity_err  (parity_err2)
`endif
    );

    typedef struct {
        logic       rst;
        logic       bv;
        logic       fs;
        logic       bi;
        logic       rdy;
        logic       ev;
        logic [7:0] ew;
        logic [3:0] ec;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs away from the edge, then settle just past the edge
    task automatic step(input logic rst, input logic bv, input logic fs,
                        input logic bi, input logic rdy);
        @(negedge clock);
        reset       = rst;
        bit_valid   = bv;
        frame_start = fs;
        bit_in      = bi;
        word_ready  = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic bv, input logic fs, input logic bi, input logic rdy,
                       input logic ev, input logic [7:0] ew, input logic [3:0] ec,
                       input logic eo);
        vec_t v;
        v.rst = 1'b0; v.bv = bv; v.fs = fs; v.bi = bi; v.rdy = rdy;
        v.ev = ev; v.ew = ew; v.ec = ec; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Send a full word LSB first, frame_start on bit 0, word_ready held at rdy
    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i == 0), w[i], rdy);
    endtask

    function automatic logic [3:0] cnt_after(input int i);
        return (i == 7) ? 4'd0 : 4'(i + 1);
    endfunction

    initial begin
        logic [7:0] a5  = 8'hA5;
        logic [7:0] c3c = 8'h3C;
        logic [7:0] c11 = 8'h11;
        logic [7:0] c22 = 8'h22;

`ifndef MUX_STREAM_DESER_PARITY_EN
        // Plain frame with ready held high
        for (int i = 0; i < 8; i++)
            add(1, (i == 0), a5[i], 1, (i == 7), (i == 7) ? 8'hA5 : 8'h00, cnt_after(i), 0);
        add(0, 0, 0, 1, 0, 8'hA5, 0, 0);
        // Bit without frame_start in IDLE is ignored
        add(1, 0, 1, 1, 0, 8'hA5, 0, 0);
        // Same word with a gap after every bit
        for (int i = 0; i < 8; i++) begin
            add(1, (i == 0), a5[i], 1, (i == 7), 8'hA5, cnt_after(i), 0);
            add(0, 0, 0, 1, 0, 8'hA5, cnt_after(i), 0);
        end
        // Partial word then restart with 0x3C
        for (int i = 0; i < 5; i++)
            add(1, (i == 0), 1, 1, 0, 8'hA5, 4'(i + 1), 0);
        for (int i = 0; i < 8; i++)
            add(1, (i == 0), c3c[i], 1, (i == 7), (i == 7) ? 8'h3C : 8'hA5, cnt_after(i), 0);
        add(0, 0, 0, 1, 0, 8'h3C, 0, 0);
        // Blocked consumer: 0x22 is dropped while 0x11 waits
        for (int i = 0; i < 8; i++)
            add(1, (i == 0), c11[i], 0, (i == 7), (i == 7) ? 8'h11 : 8'h3C, cnt_after(i), 0);
        for (int i = 0; i < 8; i++)
            add(1, (i == 0), c22[i], 0, 1, 8'h11, cnt_after(i), (i == 7));
        add(0, 0, 0, 1, 0, 8'h11, 0, 1);
        add(0, 0, 0, 0, 0, 8'h11, 0, 1);
`endif

        do_reset();
        chk("reset word_valid", word_valid, 0);
        chk("reset word_out", word_out, 0);
        chk("reset bit_count", bit_count, 0);
        chk("reset overflow", overflow, 0);
`ifdef MUX_STREAM_DESER_PARITY_EN
        chk("reset parity_err", parity_err, 0);
        chk("reset parity_err2", parity_err2, 0);
`endif

        for (int t = 0; t < tbl.size(); t++) begin
            step(tbl[t].rst, tbl[t].bv, tbl[t].fs, tbl[t].bi, tbl[t].rdy);
            chk($sformatf("vec%0d word_valid", t), word_valid, tbl[t].ev);
            chk($sformatf("vec%0d word_out", t), word_out, tbl[t].ew);
            chk($sformatf("vec%0d bit_count", t), bit_count, tbl[t].ec);
            chk($sformatf("vec%0d overflow", t), overflow, tbl[t].eo);
        end

`ifndef MUX_STREAM_DESER_PARITY_EN
        // Back-to-back: last bit of 0x22 lands in the same cycle 0x11 drains
        do_reset();
        send_word(8'h11, 1'b0);
        chk("b2b first valid", word_valid, 1);
        chk("b2b first word", word_out, 8'h11);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i == 0), c22[i], (i == 7));
        chk("b2b second valid", word_valid, 1);
        chk("b2b second word", word_out, 8'h22);
        chk("b2b overflow", overflow, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b drained", word_valid, 0);

        // WORD_W=2: completes on the first bit accepted in COLLECT
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("w2 count after bit0", bit_count2, 1);
        chk("w2 valid after bit0", word_valid2, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("w2 valid", word_valid2, 1);
        chk("w2 word", word_out2, 2'b01);
        chk("w2 count", bit_count2, 0);
        chk("w2 overflow", overflow2, 0);
`else
        // Parity-enabled build: good then bad parity on 0x07
        do_reset();
        send_word(8'h07, 1'b1);
        chk("par data-only valid", word_valid, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("par good valid", word_valid, 1);
        chk("par good word", word_out, 8'h07);
        chk("par good err", parity_err, 0);
        send_word(8'h07, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("par bad valid", word_valid, 1);
        chk("par bad word", word_out, 8'h07);
        chk("par bad err", parity_err, 1);
        chk("par overflow", overflow, 0);
        // Restart during PARITY abandons the word
        send_word(8'h55, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i == 0), c3c[i], 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("par restart word", word_out, 8'h3C);
        chk("par restart err", parity_err, 0);
`endif

        // Reset while a word is pending and another is in progress
        do_reset();
        send_word(8'h11, 1'b0);
        chk("midrst pending valid", word_valid, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("midrst count", bit_count, 3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("midrst word_valid", word_valid, 0);
        chk("midrst word_out", word_out, 0);
        chk("midrst bit_count", bit_count, 0);
        chk("midrst overflow", overflow, 0);
`ifdef MUX_STREAM_DESER_PARITY_EN
        chk("midrst parity_err", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
